mic_record_ctrl: RTL and testbench

- Sequencer for the PDM microphone capture/playback path: generates mclk, runs mic warm-up, decimates PDM bits into 8-bit PCM words and writes them to an external sample RAM.
- On command, replays the stored words to the PWM amplifier stage at the same sample rate.
- Sits between the top level, the sample RAM (BRAM, 1-cycle read latency) and the pwm block.

---
 rtl/mic_record_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mic_record_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic_record_ctrl.sv
// PDM microphone record / PWM playback sequencer driving an external 1-cycle-latency sample RAM.
// Define CTRL_STEREO_EN for stereo capture (L on mclk rise, R on mclk fall) and paired playback.
//
// state  | meaning
// IDLE   | waiting for start
// WARMUP | mclk running, discarding mic start-up rises
// REC    | decimating PDM bits into PCM words, writing RAM
// PLAY   | reading RAM words out to the pwm block at the sample rate
// FINISH | one-cycle done pulse
module mic_record_ctrl #(
  parameter int CLK_DIV = 50,
  parameter int DEC     = 64,
  parameter int ADDR_W  = 14,
  parameter int WARMUP  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  input  logic              lr_sel,
  input  logic              micData,
  output logic              mclk,
  output logic              micLRSel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pcm_out,
  output logic              pcm_valid,
  output logic              ampSD,
  output logic              busy,
  output logic              done
);

  localparam int LD    = $clog2(DEC);
  localparam int AW    = LD + 1;
  localparam int SH    = 8 - LD;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int WU_W  = $clog2(WARMUP) + 1;
  localparam int PER   = 2 * CLK_DIV * DEC;
  localparam int TMR_W = $clog2(PER);

  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [WU_W-1:0]  WU_LOAD   = WU_W'(WARMUP - 1);
  localparam logic [LD-1:0]    SAMP_LOAD = LD'(DEC - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(PER - 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_REC, S_PLAY, S_FINISH} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [WU_W-1:0]   wu_cnt;
  logic [LD-1:0]     samp_cnt;
  logic [AW-1:0]     acc_l, full_l;
  logic [ADDR_W-1:0] rem, addr;
  logic [7:0]        wdata, pcm_q;
  logic [TMR_W-1:0]  tmr;
  logic              we_q, lr_q, rd, rd_d1, valid_q;
  logic              run, run_nx, rise_tick, fall_tick;
`ifdef CTRL_STEREO_EN
  logic [AW-1:0]     acc_r;
  logic [7:0]        wdata_r;
  logic              wr2, rd2;
`endif

  // count << (8 - log2(DEC)) reaches 256 only for a full count; clamp it
  function automatic logic [7:0] to_pcm(input logic [AW-1:0] cnt);
    logic [8:0] scaled;
    scaled = 9'(cnt) << SH;
    return scaled[8] ? 8'hFF : scaled[7:0];
  endfunction

  assign run       = (state == S_WARMUP) || (state == S_REC);
  assign rise_tick = run && (div_cnt == '0) && !mclk;
  assign fall_tick = run && (div_cnt == '0) && mclk;
  assign full_l    = acc_l + AW'(micData);
`ifdef CTRL_STEREO_EN
  assign rd        = (state == S_PLAY) && ((tmr == '0) || rd2);
`else
  assign rd        = (state == S_PLAY) && (tmr == '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_we    = we_q & ~abort;
    pcm_valid = valid_q & ~abort;
    done      = (state == S_FINISH) & ~abort;
    busy      = (state != S_IDLE);
    ampSD     = (state == S_PLAY);
    mem_addr  = addr;
    mem_wdata = wdata;
    pcm_out   = pcm_q;
`ifdef CTRL_STEREO_EN
    micLRSel  = 1'b0;
`else
    micLRSel  = lr_q;
`endif
    case (state)
      S_IDLE:   if (start) state_nx = (len == '0) ? S_FINISH : (mode ? S_PLAY : S_WARMUP);
      S_WARMUP: if (rise_tick && wu_cnt == '0) state_nx = S_REC;
      S_REC:    if (we_q && rem == ADDR_W'(1)) state_nx = S_FINISH;
      S_PLAY:   if (valid_q && rem == ADDR_W'(1)) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
    run_nx = (state_nx == S_WARMUP) || (state_nx == S_REC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mclk     <= 1'b0;
      div_cnt  <= '0;
      wu_cnt   <= '0;
      samp_cnt <= '0;
      acc_l    <= '0;
      rem      <= '0;
      addr     <= '0;
      we_q     <= 1'b0;
      wdata    <= '0;
      lr_q     <= 1'b0;
      tmr      <= '0;
      rd_d1    <= 1'b0;
      valid_q  <= 1'b0;
      pcm_q    <= '0;
`ifdef CTRL_STEREO_EN
      acc_r    <= '0;
      wdata_r  <= '0;
      wr2      <= 1'b0;
      rd2      <= 1'b0;
`endif
    end else if (abort) begin
      mclk     <= 1'b0;
      div_cnt  <= DIV_LOAD;
      samp_cnt <= SAMP_LOAD;
      acc_l    <= '0;
      we_q     <= 1'b0;
      rd_d1    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef CTRL_STEREO_EN
      acc_r    <= '0;
      wr2      <= 1'b0;
      rd2      <= 1'b0;
`endif
    end else begin
      // mclk phase carries across WARMUP -> REC; any other state parks it low
      if (run && run_nx) begin
        if (div_cnt == '0) begin
          mclk    <= ~mclk;
          div_cnt <= DIV_LOAD;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end else begin
        mclk    <= 1'b0;
        div_cnt <= DIV_LOAD;
      end

      if (state == S_IDLE && start) begin
        lr_q     <= lr_sel;
        rem      <= len;
        addr     <= '0;
        wu_cnt   <= WU_LOAD;
        samp_cnt <= SAMP_LOAD;
        acc_l    <= '0;
        tmr      <= '0;
      end

      if (state == S_WARMUP && rise_tick) wu_cnt <= wu_cnt - 1'b1;

      if (we_q || valid_q) rem <= rem - 1'b1;
      if (we_q || rd) addr <= addr + 1'b1;
`ifdef CTRL_STEREO_EN
      we_q <= wr2;
      wr2  <= 1'b0;
      if (wr2) wdata <= wdata_r;
`else
      we_q <= 1'b0;
`endif

      if (state == S_REC && rise_tick) begin
        if (samp_cnt == '0) begin
          samp_cnt <= SAMP_LOAD;
          acc_l    <= '0;
          wdata    <= to_pcm(full_l);
          we_q     <= 1'b1;
`ifdef CTRL_STEREO_EN
          wdata_r  <= to_pcm(acc_r);
          acc_r    <= '0;
          wr2      <= 1'b1;
`endif
        end else begin
          samp_cnt <= samp_cnt - 1'b1;
          acc_l    <= full_l;
        end
      end
`ifdef CTRL_STEREO_EN
      if (state == S_REC && fall_tick) acc_r <= acc_r + AW'(micData);
      rd2 <= (state == S_PLAY) && (tmr == '0);
`endif

      if (state == S_PLAY) tmr <= (tmr == '0) ? TMR_LOAD : tmr - 1'b1;
      rd_d1   <= rd;
      valid_q <= rd_d1;
      if (rd_d1) pcm_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mic_record_ctrl.sv
// Scoreboard bench for mic_record_ctrl: directed record/play/abort/edge vectors, queued expectations.
module tb_mic_record_ctrl;
  localparam int CLK_DIV = 2;
  localparam int DEC     = 8;
  localparam int ADDR_W  = 4;
  localparam int WARMUP  = 4;

  logic clk = 1'b0;
  logic reset, start, mode, abort, lr_sel, mic_data;
  logic [ADDR_W-1:0] len;
  logic mclk, mic_lr_sel, mem_we, pcm_valid, amp_sd, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, pcm_out;

  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] ram [16];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic alt_en;

  typedef struct { int addr; int data; int at; } exp_t;
  exp_t wq[$];
  exp_t pq[$];

  mic_record_ctrl #(.CLK_DIV(CLK_DIV), .DEC(DEC), .ADDR_W(ADDR_W), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort), .len(len),
    .lr_sel(lr_sel), .micData(mic_data), .mclk(mclk), .micLRSel(mic_lr_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid), .ampSD(amp_sd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sample RAM with 1-cycle read latency and a side port for preloading
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_start(input logic m, input int n, input logic lr);
    @(negedge clk);
    start = 1'b1; mode = m; len = ADDR_W'(n); lr_sel = lr;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
  endtask

  function automatic exp_t mk(input int a, input int d, input int t);
    exp_t e;
    e.addr = a; e.data = d; e.at = t;
    return e;
  endfunction

  initial begin
    int c, at, n_done;
    reset = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; lr_sel = 1'b0;
    mic_data = 1'b0; len = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; alt_en = 1'b0;

    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (mem_we) begin
            if (wq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: addr=%0d data=0x%0h cycle=%0d", mem_addr, mem_wdata, cyc);
            end else begin
              e = wq.pop_front();
              check("wr_addr", int'(mem_addr), e.addr);
              check("wr_data", int'(mem_wdata), e.data);
              check("wr_cycle", cyc, e.at);
            end
          end
          if (pcm_valid) begin
            if (pq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_pcm: data=0x%0h cycle=%0d", pcm_out, cyc);
            end else begin
              e = pq.pop_front();
              check("pcm_data", int'(pcm_out), e.data);
              check("pcm_cycle", cyc, e.at);
            end
          end
        end
      end
      forever begin
        @(negedge mclk);
        if (alt_en) mic_data = ~mic_data;
      end
    join_none

    // reset values
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({mclk, mic_lr_sel, mem_addr, mem_wdata, mem_we, pcm_out,
                                 pcm_valid, amp_sd, busy, done}), 0);
    @(negedge clk);
    reset = 1'b1;

    // record all-ones, 3 words: 4 warm-up rises, then one word every 32 clk
    mic_data = 1'b1;
    pulse_start(1'b0, 3, 1'b0);
    c = cyc;
    wq.push_back(mk(0, 8'hFF, c + 46));
    wq.push_back(mk(1, 8'hFF, c + 78));
    wq.push_back(mk(2, 8'hFF, c + 110));
    check("rec_busy", int'(busy), 1);
    wait_until(c + 2);
    check("warmup_mclk_high", int'(mclk), 1);
    wait_done(200, at);
    check("rec_done_cycle", at, c + 111);
    @(negedge clk);
    check("rec_busy_low", int'(busy), 0);

    // abort during the second sample: no write, no done, mclk parked
    pulse_start(1'b0, 3, 1'b0);
    c = cyc;
    wq.push_back(mk(0, 8'hFF, c + 46));
    wait_until(c + 60);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", int'(busy), 0);
    check("abort_mclk", int'(mclk), 0);
    n_done = int'(done);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // alternating PDM, one word: 4 ones of 8 -> 0x80; also proves the aborted partial sum was dropped
    alt_en = 1'b1;
    pulse_start(1'b0, 1, 1'b1);
    c = cyc;
    wq.push_back(mk(0, 8'h80, c + 46));
    check("lr_sel_latched", int'(mic_lr_sel), 1);
    wait_done(100, at);
    check("alt_done_cycle", at, c + 47);
    alt_en = 1'b0;

    // playback of two preloaded words
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 4'd0; pre_data = 8'h10;
    @(negedge clk);
    pre_addr = 4'd1; pre_data = 8'h20;
    @(negedge clk);
    pre_we = 1'b0;
    pulse_start(1'b1, 2, 1'b0);
    c = cyc;
    pq.push_back(mk(0, 8'h10, c + 2));
    pq.push_back(mk(0, 8'h20, c + 34));
    wait_until(c + 1);
    check("play_amp_on", int'(amp_sd), 1);
    wait_until(c + 20);
    check("play_mclk_low", int'(mclk), 0);
    wait_done(100, at);
    check("play_done_cycle", at, c + 35);
    check("play_amp_off", int'(amp_sd), 0);
    @(negedge clk);
    check("play_pcm_hold", int'(pcm_out), 8'h20);

    // len=0: done the next clk, no RAM access
    pulse_start(1'b0, 0, 1'b0);
    check("len0_done", int'(done), 1);
    @(negedge clk);
    check("len0_done_low", int'(done), 0);
    check("len0_idle", int'(busy), 0);

    // start while busy is ignored
    mic_data = 1'b1;
    pulse_start(1'b0, 1, 1'b0);
    c = cyc;
    wq.push_back(mk(0, 8'hFF, c + 46));
    wait_until(c + 10);
    pulse_start(1'b1, 2, 1'b0);
    check("busy_start_no_play", int'(amp_sd), 0);
    check("busy_start_still_busy", int'(busy), 1);
    wait_done(100, at);
    check("busy_start_done_cycle", at, c + 47);

    // async reset mid-REC clears every output at once
    pulse_start(1'b0, 2, 1'b1);
    c = cyc;
    wait_until(c + 30);
    check("midrec_lrsel", int'(mic_lr_sel), 1);
    check("midrec_mclk", int'(mclk), 1);
    reset = 1'b0;
    #1;
    check("midrec_reset_outputs", int'({mclk, mic_lr_sel, mem_addr, mem_wdata, mem_we, pcm_out,
                                        pcm_valid, amp_sd, busy, done}), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    check("post_reset_mclk", int'(mclk), 0);

    repeat (5) @(negedge clk);
    check("writes_outstanding", wq.size(), 0);
    check("pcm_outstanding", pq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
